bufferm_rd_seq: RTL and testbench

Read sequencer that sits directly upstream of a PE's `bufferM` constant ROM and consumes its registered output. It accepts a strided read request (base, count, stride), drives `rd_addr` one word per cycle, and absorbs the ROM's fixed one-cycle read latency. Returned words go into a 4-entry output queue with valid/ready backpressure, so the PE operand path can stall without losing data.

---
 rtl/bufferm_rd_seq_pkg.sv | 15 +
 rtl/bufferm_rd_seq_meta_rd_fifo.sv | 73 +++++++
 rtl/bufferm_rd_seq.sv | 146 ++++++++++++++
 tb/tb_bufferm_rd_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/bufferm_rd_seq_pkg.sv
// Shared types and constants for the bufferM read sequencer.
package bufferm_rd_seq_pkg;

    // FSM states; encodings are fixed so waveforms match the ROM-side documentation.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDrain = 2'd2
    } state_e;

    // Output queue depth and the width of its occupancy count (0..MetaQDepth).
    localparam int unsigned MetaQDepth = 4;
    localparam int unsigned MetaQCntW  = $clog2(MetaQDepth + 1);

endpackage

// File: rtl/bufferm_rd_seq_meta_rd_fifo.sv
// Small synchronous FIFO holding returned ROM words plus their last-word tag.
module bufferm_rd_seq_meta_rd_fifo
    import bufferm_rd_seq_pkg::*;
#(
    parameter int unsigned Width = 33
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 push_i,
    input  logic [Width-1:0]     push_data_i,
    input  logic                 pop_i,
    output logic [Width-1:0]     head_o,
    output logic                 valid_o,
    output logic [MetaQCntW-1:0] count_o
);

    localparam int unsigned PtrW = $clog2(MetaQDepth);

    logic [Width-1:0]     mem_q [MetaQDepth];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [MetaQCntW-1:0] count_q, count_d;
    logic                 pop_ok;

    assign pop_ok = pop_i & (count_q != '0);

    // Pointer and occupancy next-state; push+pop together leaves the count unchanged.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push_i, pop_ok})
            2'b10:   count_d = count_q + MetaQCntW'(1);
            2'b01:   count_d = count_q - MetaQCntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only observed through the valid-gated head.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign valid_o = (count_q != '0);
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

    // The upstream issue throttle must never let a push land on a full queue.
    assert property (@(posedge clk_i) disable iff (reset_i)
        !(push_i && !pop_ok && (count_q == MetaQCntW'(MetaQDepth))));

endmodule

// File: rtl/bufferm_rd_seq.sv
// Strided read sequencer for the bufferM constant ROM with a backpressured output queue.
module bufferm_rd_seq
    import bufferm_rd_seq_pkg::*;
#(
    parameter int unsigned addrLen = 10,
    parameter int unsigned dataLen = 32,
    parameter int unsigned cntLen  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [addrLen-1:0] req_base,
    input  logic [cntLen-1:0]  req_count,
    input  logic [addrLen-1:0] req_stride,
    output logic [addrLen-1:0] rd_addr,
    input  logic [dataLen-1:0] rd_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [dataLen-1:0] out_data,
    output logic               out_last,
    output logic               busy,
    output logic               done
);

    state_e               state_q, state_d;
    logic [addrLen-1:0]   cur_addr_q, cur_addr_d;
    logic [addrLen-1:0]   stride_q, stride_d;
    logic [cntLen-1:0]    remain_q, remain_d;
    logic [addrLen-1:0]   rd_addr_q, rd_addr_d;
    // Two-stage tag pipeline: stage 1 = ROM sampling the address, stage 2 = data on rd_data.
    logic                 p1_q, p1_d, p2_q, p2_d;
    logic                 lt1_q, lt1_d, lt2_q, lt2_d;
    logic                 done_q, done_d;

    logic                 issue, issue_last;
    logic [addrLen-1:0]   issue_addr;
    logic [MetaQCntW-1:0] q_count, occupancy;
    logic                 pop;
    logic [dataLen:0]     head;

    // Pop is not credited: occupancy uses the registered count only.
    assign occupancy = q_count + MetaQCntW'(p1_q) + MetaQCntW'(p2_q);
    assign pop       = out_valid & out_ready;

    // Next-state for FSM, address/remain counters and the pending-read pipeline.
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        stride_d   = stride_q;
        remain_d   = remain_q;
        done_d     = 1'b0;
        issue      = 1'b0;
        issue_last = 1'b0;
        issue_addr = cur_addr_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    stride_d = req_stride;
                    if (req_count == '0) begin
                        done_d = 1'b1;
                    end else begin
                        // The handshake cycle doubles as the first issue slot; queue is empty.
                        issue      = 1'b1;
                        issue_addr = req_base;
                        issue_last = (req_count == cntLen'(1));
                        remain_d   = req_count - cntLen'(1);
                        cur_addr_d = req_base + req_stride;
                        state_d    = issue_last ? StDrain : StIssue;
                    end
                end
            end
            StIssue: begin
                if (occupancy < MetaQCntW'(MetaQDepth)) begin
                    issue      = 1'b1;
                    issue_last = (remain_q == cntLen'(1));
                    remain_d   = remain_q - cntLen'(1);
                    cur_addr_d = cur_addr_q + stride_q;
                    if (issue_last) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (pop && out_last) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        rd_addr_d = issue ? issue_addr : rd_addr_q;
        p1_d      = issue;
        lt1_d     = issue_last;
        p2_d      = p1_q;
        lt2_d     = lt1_q;
    end

    // All sequencer state; reset drops in-flight reads so stale ROM data is never queued.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cur_addr_q <= '0;
            stride_q   <= '0;
            remain_q   <= '0;
            rd_addr_q  <= '0;
            p1_q       <= 1'b0;
            p2_q       <= 1'b0;
            lt1_q      <= 1'b0;
            lt2_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            stride_q   <= stride_d;
            remain_q   <= remain_d;
            rd_addr_q  <= rd_addr_d;
            p1_q       <= p1_d;
            p2_q       <= p2_d;
            lt1_q      <= lt1_d;
            lt2_q      <= lt2_d;
            done_q     <= done_d;
        end
    end

    bufferm_rd_seq_meta_rd_fifo #(
        .Width (dataLen + 1)
    ) u_meta_rd_fifo (
        .clk_i       (clk),
        .reset_i     (reset),
        .push_i      (p2_q),
        .push_data_i ({lt2_q, rd_data}),
        .pop_i       (pop),
        .head_o      (head),
        .valid_o     (out_valid),
        .count_o     (q_count)
    );

    assign out_data  = head[dataLen-1:0];
    assign out_last  = head[dataLen];
    assign rd_addr   = rd_addr_q;
    assign req_ready = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign done      = done_q;

endmodule

// File: tb/tb_bufferm_rd_seq.sv
// Scoreboard bench: stimulus queues expected words, a negedge monitor checks every handshake.
module tb_bufferm_rd_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [9:0]  req_base;
    logic [9:0]  req_count;
    logic [9:0]  req_stride;
    logic [9:0]  rd_addr;
    logic [31:0] rd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int exp_done = 0;
    logic [32:0] exp_q [$];

    bufferm_rd_seq dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_base   (req_base),
        .req_count  (req_count),
        .req_stride (req_stride),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // bufferM model: registered read, data[i] = i + 100.
    always @(posedge clk) rd_data <= 32'(rd_addr) + 32'd100;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Monitor: compare every accepted output word and account for done pulses.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    logic [32:0] e;
                    e = exp_q.pop_front();
                    check("out_data", 64'(out_data), 64'(e[31:0]));
                    check("out_last", 64'(out_last), 64'(e[32]));
                end
            end
            if (done) begin
                done_cnt++;
                check("done_sb_empty", 64'(exp_q.size()), 64'd0);
            end
        end
    end

    // Issue one request; returns one edge after the handshake (start of cycle 1).
    task automatic send(input logic [9:0] b, input logic [9:0] c, input logic [9:0] s);
        int k = 0;
        logic [9:0] a;
        @(negedge clk);
        while (!req_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("req_ready_wait", 64'(req_ready), 64'd1);
        req_valid  = 1'b1;
        req_base   = b;
        req_count  = c;
        req_stride = s;
        a = b;
        for (int i = 0; i < int'(c); i++) begin
            exp_q.push_back({(i == int'(c) - 1), 32'(a) + 32'd100});
            a = a + s;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        @(negedge clk);
        while (!done && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("done_seen", 64'(done), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] wrap_addr [4];
        wrap_addr[0] = 10'd1022;
        wrap_addr[1] = 10'd1023;
        wrap_addr[2] = 10'd0;
        wrap_addr[3] = 10'd1;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_base   = '0;
        req_count  = '0;
        req_stride = '0;
        out_ready  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Basic strided read: exact cycle timing.
        send(10'd0, 10'd4, 10'd1);
        exp_done++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("basic_rd_addr", 64'(rd_addr), 64'(i));
            if (i == 1) check("basic_no_valid_c2", 64'(out_valid), 64'd0);
            if (i == 2) check("basic_valid_c3", 64'(out_valid), 64'd1);
        end
        @(negedge clk);
        @(negedge clk);
        check("basic_done_c6", 64'(done), 64'd0);
        @(negedge clk);
        check("basic_done_c7", 64'(done), 64'd1);

        // Zero count: done next cycle, nothing else moves.
        send(10'd555, 10'd0, 10'd7);
        exp_done++;
        @(negedge clk);
        check("zero_done", 64'(done), 64'd1);
        check("zero_busy", 64'(busy), 64'd0);
        check("zero_out_valid", 64'(out_valid), 64'd0);
        check("zero_rd_addr", 64'(rd_addr), 64'd3);
        @(negedge clk);
        check("zero_done_once", 64'(done), 64'd0);
        check("zero_busy_c2", 64'(busy), 64'd0);

        // Address wrap, then zero stride.
        send(10'd1022, 10'd4, 10'd1);
        exp_done++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("wrap_rd_addr", 64'(rd_addr), 64'(wrap_addr[i]));
        end
        wait_done();
        send(10'd7, 10'd3, 10'd0);
        exp_done++;
        wait_done();

        // Backpressure: consumer stalls through cycle 12.
        out_ready = 1'b0;
        send(10'd200, 10'd10, 10'd3);
        exp_done++;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 8) check("bp_hold_addr_c8", 64'(rd_addr), 64'd209);
            if (c == 8) check("bp_busy", 64'(busy), 64'd1);
        end
        check("bp_hold_addr_c12", 64'(rd_addr), 64'd209);
        check("bp_valid_held", 64'(out_valid), 64'd1);
        check("bp_head", 64'(out_data), 64'd300);
        check("bp_no_done", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_done();

        // Reset mid-request in cycle 5.
        send(10'd50, 10'd20, 10'd1);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_req_ready", 64'(req_ready), 64'd1);
        check("mid_rst_done", 64'(done), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("post_rst_quiet", 64'({done, out_valid, busy}), 64'd0);
        end
        send(10'd900, 10'd2, 10'd5);
        exp_done++;
        wait_done();

        repeat (3) @(negedge clk);
        check("final_sb_empty", 64'(exp_q.size()), 64'd0);
        check("final_done_count", 64'(done_cnt), 64'(exp_done));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
